acond_entradas: RTL and testbench
=================================

Name: acond_entradas

Overview:
- Input-conditioning stage directly upstream of the turn-signal state machine (`salidas`).
- Takes four raw, asynchronous switch lines: left 1/2 and right 1/2.
- Synchronizes and debounces each line, then arbitrates so that at most one of I1/I2/D1/D2 is high.
- Drives registered, glitch-free I1, I2, D1, D2 straight into the downstream FSM.

Parameters:
- DEB_CYCLES, 4: consecutive stable synchronized cycles required before a debounced level changes. Legal range 1..2^CNT_W.
- CNT_W, 3: width of each per-input debounce counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- raw_i1  input  1  raw left switch 1; asynchronous.
- raw_i2  input  1  raw left switch 2; asynchronous.
- raw_d1  input  1  raw right switch 1; asynchronous.
- raw_d2  input  1  raw right switch 2; asynchronous.
- I1  output  1  conditioned left-1 request; registered.
- I2  output  1  conditioned left-2 request; registered.
- D1  output  1  conditioned right-1 request; registered.
- D2  output  1  conditioned right-2 request; registered.
- cambio  output  1  one-cycle pulse, coincident with the first cycle of any change of {I1,I2,D1,D2}.
- conflicto  output  1  left/right conflict flag; see Optional Feature.

Behaviour:
- Reset: on the edge where reset=1, clear everything to 0:
  - sync flops, debounced levels, counters;
  - I1, I2, D1, D2, cambio, conflicto.
  - FSM goes to NINGUNO.
  - Reset mid-operation discards all in-flight debounce progress. There is no partial state.
- Synchronizer: two flops per raw input.
- Debounce, per input, evaluated each edge:
  - If sync == deb: counter <= 0.
  - Else, if counter == DEB_CYCLES-1: deb <= sync, counter <= 0.
  - Else: counter <= counter+1.
  - Any pulse or glitch shorter than DEB_CYCLES synchronized cycles is ignored; the counter restarts whenever sync returns to deb.
- Latency:
  - A raw level first sampled at edge n updates deb at edge n+1+DEB_CYCLES.
  - The corresponding output changes at edge n+2+DEB_CYCLES.
  - Release latency is identical.
- Arbitration FSM states: NINGUNO, G_I1, G_I2, G_D1, G_D2.
- Fixed priority I1 > I2 > D1 > D2.
- From NINGUNO: go to the highest-priority input whose deb=1; stay in NINGUNO if none.
- From G_x: stay while deb_x=1, even if a higher-priority deb rises. The owner is locked.
- When deb_x=0: in the same edge, go to the highest-priority remaining deb=1, else NINGUNO. There is no idle cycle between owners.
- Outputs: one-hot decode of the state, registered. All zero in NINGUNO. Never more than one output high.
- cambio: high for exactly one cycle whenever the registered output vector differs from its previous value. Held 0 in reset.
- Simultaneous deb rises on the same edge are resolved by priority.
- Simultaneous owner release plus another rise on the same edge: the new rise is eligible in that same arbitration.

Optional Feature:
- Macro: ACOND_CONFLICT_EN.
- Defined:
  - Adds state BLOQUEO.
  - From any state, if (deb_i1|deb_i2) & (deb_d1|deb_d2) on an edge: enter BLOQUEO. Outputs go to 0; conflicto=1 starting the next cycle; cambio pulses if the outputs changed.
  - Leave BLOQUEO when the conflict term is 0 and arbitrate as from NINGUNO in the same edge; conflicto returns to 0.
- Not defined:
  - conflicto is tied to 0.
  - Plain priority arbitration applies, and the left/right overlap grants per the lock rule.

Test Plan:
- Reset and idle: reset pulse with all raw=0 → all outputs 0, cambio=0 for 20 cycles.
- Latency: DEB_CYCLES=4, raw_i1 0→1, first sampled at edge n → I1=1 exactly at edge n+6 and cambio=1 for that single cycle; raw_i1 1→0 sampled at edge m → I1=0 at edge m+6.
- Glitch rejection: raw_d1 high for 3 cycles then low (DEB_CYCLES=4) → D1 stays 0 and cambio stays 0 throughout.
- Lock and handover: raw_i2 steady high, I2 granted; then raw_i1 goes high → I2 stays 1. Drop raw_i2 → at the edge I2 falls, I1=1 in the same edge with a single cambio pulse.
- Conflict with ACOND_CONFLICT_EN:
  - raw_i1 and raw_d2 high together → all outputs 0 and conflicto=1.
  - Drop raw_d2 → I1=1 and conflicto=0 on the same edge.
- Conflict without ACOND_CONFLICT_EN: same stimulus → I1=1 and conflicto=0. Reset asserted mid-debounce → all outputs 0 on that edge, and re-qualification takes the full DEB_CYCLES+2 latency.

Source files
------------

// File: rtl/acond_entradas.sv
// acond_entradas: input conditioning ahead of the turn-signal FSM (salidas).
//
// Each of the four raw switch lines is synchronized through two flops, then
// debounced: the debounced level follows the synchronized level only after it
// has differed for DEB_CYCLES consecutive cycles. A fixed-priority arbiter
// (I1 > I2 > D1 > D2) with owner locking then grants at most one request.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   raw_i1/i2  raw left switches (asynchronous)
//   raw_d1/d2  raw right switches (asynchronous)
//   I1,I2,D1,D2  registered, one-hot-or-zero conditioned requests
//   cambio     one-cycle pulse on the first cycle of any change of {I1,I2,D1,D2}
//   conflicto  left/right conflict flag (constant 0 unless ACOND_CONFLICT_EN)
//
// Build option: define ACOND_CONFLICT_EN to add the BLOQUEO state, which blanks
// all requests while a left and a right switch are both debounced high.

module acond_entradas #(
   parameter int unsigned DEB_CYCLES = 4,
   parameter int unsigned CNT_W      = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i1,
   input  logic raw_i2,
   input  logic raw_d1,
   input  logic raw_d2,
   output logic I1,
   output logic I2,
   output logic D1,
   output logic D2,
   output logic cambio,
   output logic conflicto
);

   // Terminal count of the debounce counter.
   localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEB_CYCLES - 1);

   typedef enum logic [2:0] {
      StNinguno,
      StGI1,
      StGI2,
      StGD1,
`ifdef ACOND_CONFLICT_EN
      StGD2,
      StBloqueo
`else
      StGD2
`endif
   } state_e;

   // Bit order everywhere: [0]=I1, [1]=I2, [2]=D1, [3]=D2 (priority order).
   logic [3:0]       raw;
   logic [3:0]       sync1_q;
   logic [3:0]       sync2_q;
   logic [3:0]       deb_q;
   logic [CNT_W-1:0] cnt_q [4];

   state_e     state_q;
   state_e     state_d;
   state_e     first_req;
   logic [3:0] out_d;
   logic [3:0] out_q;
   logic       cambio_q;

   assign raw = {raw_d2, raw_d1, raw_i2, raw_i1};

   // Synchronizers and debouncers.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         deb_q   <= '0;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
               // Any return to the debounced level restarts qualification.
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CntMax) begin
               deb_q[i] <= sync2_q[i];
               cnt_q[i] <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StNinguno;
         out_q    <= '0;
         cambio_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         out_q    <= out_d;
         cambio_q <= (out_d != out_q);
      end
   end

   // Next-state: fixed priority, current owner locked while its request holds.
   always_comb begin
      first_req = StNinguno;
      if (deb_q[0]) begin
         first_req = StGI1;
      end else if (deb_q[1]) begin
         first_req = StGI2;
      end else if (deb_q[2]) begin
         first_req = StGD1;
      end else if (deb_q[3]) begin
         first_req = StGD2;
      end

      state_d = first_req;
      case (state_q)
         StGI1:   state_d = deb_q[0] ? StGI1 : first_req;
         StGI2:   state_d = deb_q[1] ? StGI2 : first_req;
         StGD1:   state_d = deb_q[2] ? StGD1 : first_req;
         StGD2:   state_d = deb_q[3] ? StGD2 : first_req;
         default: state_d = first_req;
      endcase

`ifdef ACOND_CONFLICT_EN
      // Conflict overrides everything, including a locked owner.
      if ((deb_q[0] | deb_q[1]) & (deb_q[2] | deb_q[3])) begin
         state_d = StBloqueo;
      end
`endif
   end

   // Output decode of the next state, so the registered outputs change on the
   // same edge as the state register.
   always_comb begin
      out_d = '0;
      case (state_d)
         StGI1:   out_d = 4'b0001;
         StGI2:   out_d = 4'b0010;
         StGD1:   out_d = 4'b0100;
         StGD2:   out_d = 4'b1000;
         default: out_d = 4'b0000;
      endcase
   end

`ifdef ACOND_CONFLICT_EN
   logic conflicto_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         conflicto_q <= 1'b0;
      end else begin
         conflicto_q <= (state_d == StBloqueo);
      end
   end

   assign conflicto = conflicto_q;
`else
   assign conflicto = 1'b0;
`endif

   assign I1     = out_q[0];
   assign I2     = out_q[1];
   assign D1     = out_q[2];
   assign D2     = out_q[3];
   assign cambio = cambio_q;

endmodule

// File: tb/tb_acond_entradas.sv
// Testbench for acond_entradas: directed scenarios plus randomized switch
// activity checked against a sliding-window / priority reference model.

module tb_acond_entradas;

   localparam int unsigned DEB  = 4;
   localparam int          NONE = -1;
   localparam int          BLK  = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic raw_i1 = 1'b0;
   logic raw_i2 = 1'b0;
   logic raw_d1 = 1'b0;
   logic raw_d2 = 1'b0;
   logic I1, I2, D1, D2, cambio, conflicto;
   logic [3:0] outv;

   int n_checks = 0;
   int n_fail = 0;

   // Reference model state.
   logic [3:0] m_hist [DEB+1];  // raw vectors sampled at past edges, [0] newest
   logic [3:0] m_deb;
   int         m_owner;
   logic [3:0] m_out;
   logic       m_cambio;
   logic       m_conf;

   assign outv = {D2, D1, I2, I1};

   always #5 clk = ~clk;

   acond_entradas #(
      .DEB_CYCLES(DEB),
      .CNT_W(3)
   ) dut (
      .clk(clk),
      .reset(reset),
      .raw_i1(raw_i1),
      .raw_i2(raw_i2),
      .raw_d1(raw_d1),
      .raw_d2(raw_d2),
      .I1(I1),
      .I2(I2),
      .D1(D1),
      .D2(D2),
      .cambio(cambio),
      .conflicto(conflicto)
   );

   function automatic int arbitrate(input int cur, input logic [3:0] d);
`ifdef ACOND_CONFLICT_EN
      if ((d[0] | d[1]) & (d[2] | d[3])) return BLK;
`endif
      if (cur >= 0 && cur < 4) begin
         if (d[cur]) return cur;
      end
      for (int i = 0; i < 4; i++) begin
         if (d[i]) return i;
      end
      return NONE;
   endfunction

   function automatic logic [3:0] onehot(input int o);
      logic [3:0] v;
      v = '0;
      if (o >= 0 && o < 4) v[o] = 1'b1;
      return v;
   endfunction

   // One clock edge of the model. A debounced level flips once the line seen
   // through the two-flop synchronizer has disagreed with it for DEB edges.
   task automatic model_edge(input logic rst, input logic [3:0] r);
      int         nxt;
      logic [3:0] new_out;
      logic       flip;
      if (rst) begin
         for (int k = 0; k <= DEB; k++) m_hist[k] = '0;
         m_deb    = '0;
         m_owner  = NONE;
         m_out    = '0;
         m_cambio = 1'b0;
         m_conf   = 1'b0;
      end else begin
         nxt      = arbitrate(m_owner, m_deb);
         new_out  = onehot(nxt);
         m_cambio = (new_out != m_out);
         m_out    = new_out;
         m_owner  = nxt;
         m_conf   = (nxt == BLK);
         for (int i = 0; i < 4; i++) begin
            flip = 1'b1;
            for (int k = 1; k <= DEB; k++) begin
               if (m_hist[k][i] == m_deb[i]) flip = 1'b0;
            end
            if (flip) m_deb[i] = ~m_deb[i];
         end
         for (int k = DEB; k >= 1; k--) m_hist[k] = m_hist[k-1];
         m_hist[0] = r;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(reset, {raw_d2, raw_d1, raw_i2, raw_i1});
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      {raw_i1, raw_i2, raw_d1, raw_d2} = 4'b0000;
      step();
      step();
      n_checks++;
      if ({outv, cambio, conflicto} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_state: got %b required 000000", {outv, cambio, conflicto});
      end
      reset = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         n_checks++;
         if ({outv, cambio, conflicto} !== 6'b0) begin
            n_fail++;
            $display("FAIL idle cycle %0d: got %b required 000000", c, {outv, cambio, conflicto});
         end
      end
   endtask

   task automatic test_latency();
      int   at;
      logic camb_at;
      at = 0;
      camb_at = 1'b0;
      raw_i1 = 1'b1;
      for (int k = 1; k <= 20 && at == 0; k++) begin
         step();
         if (I1 === 1'b1) begin
            at = k;
            camb_at = cambio;
         end
      end
      n_checks++;
      if (at != 7) begin
         n_fail++;
         $display("FAIL rise_latency: got edge n+%0d required n+6", at - 1);
      end
      n_checks++;
      if (camb_at !== 1'b1) begin
         n_fail++;
         $display("FAIL rise_cambio: got %b required 1", camb_at);
      end
      step();
      n_checks++;
      if (cambio !== 1'b0 || I1 !== 1'b1) begin
         n_fail++;
         $display("FAIL cambio_width: got cambio=%b I1=%b required 0 1", cambio, I1);
      end
      for (int k = 0; k < 5; k++) step();
      at = 0;
      raw_i1 = 1'b0;
      for (int k = 1; k <= 20 && at == 0; k++) begin
         step();
         if (I1 === 1'b0) begin
            at = k;
            camb_at = cambio;
         end
      end
      n_checks++;
      if (at != 7 || camb_at !== 1'b1) begin
         n_fail++;
         $display("FAIL fall_latency: got edge n+%0d cambio=%b required n+6 1", at - 1, camb_at);
      end
      for (int k = 0; k < 5; k++) step();
   endtask

   task automatic test_glitch();
      raw_d1 = 1'b1;
      for (int k = 0; k < 18; k++) begin
         if (k == 3) raw_d1 = 1'b0;
         step();
         n_checks++;
         if (D1 !== 1'b0 || cambio !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch cycle %0d: got D1=%b cambio=%b required 0 0", k, D1, cambio);
         end
      end
   endtask

   task automatic test_lock();
      int found;
      raw_i2 = 1'b1;
      for (int k = 0; k < 8; k++) step();
      n_checks++;
      if (outv !== 4'b0010) begin
         n_fail++;
         $display("FAIL lock_grant: got %b required 0010", outv);
      end
      raw_i1 = 1'b1;
      for (int k = 0; k < 10; k++) step();
      n_checks++;
      if (outv !== 4'b0010) begin
         n_fail++;
         $display("FAIL lock_hold: got %b required 0010", outv);
      end
      raw_i2 = 1'b0;
      found = 0;
      for (int k = 0; k < 12 && found == 0; k++) begin
         step();
         if (I2 !== 1'b1) found = 1;
      end
      n_checks++;
      if (found == 0 || outv !== 4'b0001 || cambio !== 1'b1) begin
         n_fail++;
         $display("FAIL handover: got out=%b cambio=%b seen=%0d required 0001 1 1",
                  outv, cambio, found);
      end
      step();
      n_checks++;
      if (outv !== 4'b0001 || cambio !== 1'b0) begin
         n_fail++;
         $display("FAIL handover_after: got out=%b cambio=%b required 0001 0", outv, cambio);
      end
      raw_i1 = 1'b0;
      for (int k = 0; k < 10; k++) step();
   endtask

   task automatic test_conflict();
      reset = 1'b1;
      step();
      reset = 1'b0;
      raw_i1 = 1'b1;
      raw_d2 = 1'b1;
      for (int k = 0; k < 10; k++) step();
`ifdef ACOND_CONFLICT_EN
      n_checks++;
      if (outv !== 4'b0000 || conflicto !== 1'b1) begin
         n_fail++;
         $display("FAIL conflict_block: got out=%b conflicto=%b required 0000 1", outv, conflicto);
      end
      raw_d2 = 1'b0;
      begin
         int found;
         found = 0;
         for (int k = 0; k < 12 && found == 0; k++) begin
            step();
            if (I1 === 1'b1) found = 1;
         end
         n_checks++;
         if (found == 0 || conflicto !== 1'b0 || cambio !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_release: got I1=%b conflicto=%b cambio=%b required 1 0 1",
                     I1, conflicto, cambio);
         end
      end
`else
      n_checks++;
      if (outv !== 4'b0001 || conflicto !== 1'b0) begin
         n_fail++;
         $display("FAIL overlap_grant: got out=%b conflicto=%b required 0001 0", outv, conflicto);
      end
      raw_d2 = 1'b0;
      for (int k = 0; k < 10; k++) step();
      n_checks++;
      if (outv !== 4'b0001 || conflicto !== 1'b0) begin
         n_fail++;
         $display("FAIL overlap_release: got out=%b conflicto=%b required 0001 0", outv, conflicto);
      end
`endif
      raw_i1 = 1'b0;
      for (int k = 0; k < 10; k++) step();
   endtask

   task automatic test_reset_mid();
      int at;
      raw_i1 = 1'b1;
      for (int k = 0; k < 3; k++) step();
      reset = 1'b1;
      step();
      n_checks++;
      if ({outv, cambio, conflicto} !== 6'b0) begin
         n_fail++;
         $display("FAIL mid_reset: got %b required 000000", {outv, cambio, conflicto});
      end
      reset = 1'b0;
      at = 0;
      for (int k = 1; k <= 20 && at == 0; k++) begin
         step();
         if (I1 === 1'b1) at = k;
      end
      n_checks++;
      if (at != 7) begin
         n_fail++;
         $display("FAIL requalify_latency: got edge n+%0d required n+6", at - 1);
      end
      raw_i1 = 1'b0;
      for (int k = 0; k < 10; k++) step();
   endtask

   task automatic test_random();
      int hold;
      hold = 0;
      for (int c = 0; c < 3000; c++) begin
         if (hold == 0) begin
            {raw_d2, raw_d1, raw_i2, raw_i1} = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 9);
         end
         hold--;
         reset = ($urandom_range(0, 299) == 0);
         step();
         n_checks++;
         if (outv !== m_out || cambio !== m_cambio || conflicto !== m_conf) begin
            n_fail++;
            $display("FAIL random cycle %0d: got out=%b cambio=%b conflicto=%b required %b %b %b",
                     c, outv, cambio, conflicto, m_out, m_cambio, m_conf);
         end
      end
      reset = 1'b0;
      {raw_d2, raw_d1, raw_i2, raw_i1} = 4'b0000;
      for (int k = 0; k < 10; k++) step();
   endtask

   initial begin
      test_reset();
      test_latency();
      test_glitch();
      test_lock();
      test_conflict();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
